// File: rtl/arm_pkg.sv
// Shared fetch-path constants and types for the pipelined ARM core.
package arm_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'hE1A0_0000;
  localparam logic [31:0] WORD_BYTES     = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and memory.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched words with their PCs; clear empties it in one cycle.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_stage_chk.sv
// Protocol checks for the fetch stage: responses only with requests in flight, never into a full FIFO.
module fetch_stage_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic          push,
  input logic          fifo_full
);

  rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> (outstanding != '0));

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !fifo_full);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited memory requests, response buffering and IF/ID register.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 stall_d,
  input  logic                 flush_d,
  input  logic                 branch_taken_e,
  input  logic [31:0]          branch_target_e,
  output logic [31:0]          instr_d,
  output logic [31:0]          pcplus8_d,
  output logic                 instr_valid_d
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pc_r;
  logic [31:0]   rsp_pc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] outstanding_next_s;
  fetch_entry_t  head_s;
  fetch_entry_t  rsp_entry_s;
  fetch_entry_t  out_entry_s;
  logic          credit_ok_s, req_valid_s, fire_s, rsp_s, drop_s, keep_s;
  logic          advance_s, fifo_empty_s, bypass_s, push_s, pop_s;

  assign credit_ok_s  = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < (CW + 1)'(FIFO_DEPTH);
  assign req_valid_s  = reset && !branch_taken_e && credit_ok_s;
  assign fire_s       = req_valid_s && imem.imem_req_ready;
  assign rsp_s        = imem.imem_rsp_valid;
  assign drop_s       = rsp_s && (drop_cnt_r != '0);
  assign keep_s       = rsp_s && !drop_s && !branch_taken_e;
  assign advance_s    = !branch_taken_e && !flush_d && !stall_d;
  assign fifo_empty_s = (fifo_count_s == '0);
  // An arriving word goes straight to IF/ID when nothing older is buffered.
  assign bypass_s     = keep_s && fifo_empty_s && advance_s;
  assign push_s       = keep_s && !bypass_s;
  assign pop_s        = advance_s && !fifo_empty_s;
  assign rsp_entry_s  = '{instr: imem.imem_rsp_data, pc: rsp_pc_r};
  assign out_entry_s  = fifo_empty_s ? rsp_entry_s : head_s;
  assign outstanding_next_s = outstanding_r + CW'(fire_s) - CW'(rsp_s);

  assign imem.imem_req_valid = req_valid_s;
  assign imem.imem_addr      = pc_r;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (branch_taken_e),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (rsp_entry_s),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  fetch_stage_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .rst_n       (reset),
    .rsp_valid   (rsp_s),
    .outstanding (outstanding_r),
    .push        (push_s),
    .fifo_full   (fifo_count_s == CW'(FIFO_DEPTH))
  );

  // PC, next-response PC and in-flight bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r          <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else if (branch_taken_e) begin
      pc_r          <= align_word(branch_target_e);
      rsp_pc_r      <= align_word(branch_target_e);
      outstanding_r <= outstanding_next_s;
      // Every request still in flight predates the redirect, so all of them are stale.
      drop_cnt_r    <= outstanding_next_s;
    end else begin
      pc_r          <= fire_s ? (pc_r + WORD_BYTES) : pc_r;
      rsp_pc_r      <= keep_s ? (rsp_pc_r + WORD_BYTES) : rsp_pc_r;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_cnt_r - CW'(drop_s);
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_d       <= NOP_INSTR;
      pcplus8_d     <= 32'h0000_0000;
      instr_valid_d <= 1'b0;
    end else if (branch_taken_e || flush_d) begin
      instr_d       <= NOP_INSTR;
      instr_valid_d <= 1'b0;
    end else if (stall_d) begin
      instr_d       <= instr_d;
      instr_valid_d <= instr_valid_d;
    end else if (pop_s || bypass_s) begin
      instr_d       <= out_entry_s.instr;
      pcplus8_d     <= out_entry_s.pc + PC_READ_OFFSET;
      instr_valid_d <= 1'b1;
    end else begin
      instr_d       <= NOP_INSTR;
      instr_valid_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order variable-latency instruction memory model.
module tb_fetch_stage;
  import arm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_d, flush_d, branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] instr_d, pcplus8_d;
  logic        instr_valid_d;

  fetch_stage_if ifc ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (ifc),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .branch_taken_e  (branch_taken_e),
    .branch_target_e (branch_target_e),
    .instr_d         (instr_d),
    .pcplus8_d       (pcplus8_d),
    .instr_valid_d   (instr_valid_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rc;
  } mreq_t;

  mreq_t mem_q[$];
  int    cyc   = 0;
  int    lat   = 1;
  int    n_cmp = 0;
  int    n_err = 0;
  logic  found;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake at negedge, then advance the memory model after the edge.
  task automatic tick();
    logic        fired;
    logic [31:0] fa;
    @(negedge clk);
    fired = ifc.imem_req_valid && ifc.imem_req_ready;
    fa    = ifc.imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (fired) mem_q.push_back('{addr: fa, rc: cyc + lat - 1});
    if (mem_q.size() > 0 && mem_q[0].rc <= cyc) begin
      ifc.imem_rsp_valid = 1'b1;
      ifc.imem_rsp_data  = word_at(mem_q[0].addr);
    end else begin
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = 32'h0000_0000;
    end
  endtask

  task automatic wait_valid(input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (instr_valid_d) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; stall_d = 1'b0; flush_d = 1'b0; branch_taken_e = 1'b0;
    branch_target_e = 32'h0000_0000;
    ifc.imem_req_ready = 1'b1; ifc.imem_rsp_valid = 1'b0; ifc.imem_rsp_data = 32'h0000_0000;
    repeat (2) tick();

    // Reset state
    chk_eq("rst_instr", instr_d, NOP_INSTR);
    chk_eq("rst_pc8", pcplus8_d, 32'h0000_0000);
    chk_eq("rst_valid", {31'd0, instr_valid_d}, 32'd0);
    chk_eq("rst_req", {31'd0, ifc.imem_req_valid}, 32'd0);

    // 1: sequential fetch, latency 1
    reset = 1'b1;
    #1;
    chk_eq("t1_addr0", ifc.imem_addr, 32'h0000_0000);
    chk_eq("t1_req0", {31'd0, ifc.imem_req_valid}, 32'd1);
    tick();
    chk_eq("t1_addr1", ifc.imem_addr, 32'h0000_0004);
    chk_eq("t1_nvalid", {31'd0, instr_valid_d}, 32'd0);
    tick();
    chk_eq("t1_valid", {31'd0, instr_valid_d}, 32'd1);
    chk_eq("t1_instr0", instr_d, word_at(32'h0000_0000));
    chk_eq("t1_pc8_a", pcplus8_d, 32'h0000_0008);
    tick();
    chk_eq("t1_pc8_b", pcplus8_d, 32'h0000_000C);
    tick();
    chk_eq("t1_pc8_c", pcplus8_d, 32'h0000_0010);
    chk_eq("t1_addr4", ifc.imem_addr, 32'h0000_0010);

    // 2: memory not ready for 3 cycles
    ifc.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("t2_addr_hold", ifc.imem_addr, 32'h0000_0010);
      chk_eq("t2_req_hold", {31'd0, ifc.imem_req_valid}, 32'd1);
      if (i == 0) chk_eq("t2_pc8_drain", pcplus8_d, 32'h0000_0014);
      if (i == 1) chk_eq("t2_bubble", {31'd0, instr_valid_d}, 32'd0);
    end
    ifc.imem_req_ready = 1'b1;
    tick();
    chk_eq("t2_addr_adv", ifc.imem_addr, 32'h0000_0014);
    tick();
    chk_eq("t2_pc8", pcplus8_d, 32'h0000_0018);
    chk_eq("t2_instr", instr_d, word_at(32'h0000_0010));

    // 3: decode stall while the FIFO fills
    stall_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_eq("t3_pc8_hold", pcplus8_d, 32'h0000_0018);
      chk_eq("t3_instr_hold", instr_d, word_at(32'h0000_0010));
      chk_eq("t3_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    end
    chk_eq("t3_addr", ifc.imem_addr, 32'h0000_001C);
    stall_d = 1'b0;
    tick();
    chk_eq("t3_pc8_a", pcplus8_d, 32'h0000_001C);
    chk_eq("t3_instr_a", instr_d, word_at(32'h0000_0014));
    tick();
    chk_eq("t3_pc8_b", pcplus8_d, 32'h0000_0020);
    tick();
    chk_eq("t3_pc8_c", pcplus8_d, 32'h0000_0024);

    // 4: redirect with two responses in flight (latency 2)
    lat = 2;
    tick();
    chk_eq("t4_pc8_pre", pcplus8_d, 32'h0000_0028);
    tick();
    chk_eq("t4_credit_full", {31'd0, ifc.imem_req_valid}, 32'd0);
    branch_taken_e = 1'b1; branch_target_e = 32'h0000_0203;
    #1;
    chk_eq("t4_no_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    tick();
    branch_taken_e = 1'b0;
    #1;
    chk_eq("t4_nop", instr_d, NOP_INSTR);
    chk_eq("t4_nvalid", {31'd0, instr_valid_d}, 32'd0);
    chk_eq("t4_addr", ifc.imem_addr, 32'h0000_0200);
    chk_eq("t4_req", {31'd0, ifc.imem_req_valid}, 32'd1);
    wait_valid(10);
    chk_eq("t4_found", {31'd0, found}, 32'd1);
    chk_eq("t4_pc8", pcplus8_d, 32'h0000_0208);
    chk_eq("t4_instr", instr_d, word_at(32'h0000_0200));

    // 5: flush and stall together
    lat = 1;
    stall_d = 1'b1;
    repeat (2) tick();
    flush_d = 1'b1;
    tick();
    chk_eq("t5_nvalid", {31'd0, instr_valid_d}, 32'd0);
    chk_eq("t5_nop", instr_d, NOP_INSTR);
    flush_d = 1'b0; stall_d = 1'b0;
    tick();
    chk_eq("t5_valid", {31'd0, instr_valid_d}, 32'd1);
    chk_eq("t5_head", pcplus8_d, 32'h0000_020C);
    tick();
    chk_eq("t5_next", pcplus8_d, 32'h0000_0210);

    // PC wrap at the top of the address space
    branch_taken_e = 1'b1; branch_target_e = 32'hFFFF_FFFE;
    tick();
    branch_taken_e = 1'b0;
    #1;
    chk_eq("wrap_addr", ifc.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk_eq("wrap_zero", ifc.imem_addr, 32'h0000_0000);
    wait_valid(10);
    chk_eq("wrap_found", {31'd0, found}, 32'd1);
    chk_eq("wrap_pc8", pcplus8_d, 32'h0000_0004);
    chk_eq("wrap_instr", instr_d, word_at(32'hFFFF_FFFC));

    // 6: reset mid-stream
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_eq("t6_instr", instr_d, NOP_INSTR);
    chk_eq("t6_pc8", pcplus8_d, 32'h0000_0000);
    chk_eq("t6_valid", {31'd0, instr_valid_d}, 32'd0);
    chk_eq("t6_req", {31'd0, ifc.imem_req_valid}, 32'd0);
    chk_eq("t6_addr", ifc.imem_addr, 32'h0000_0000);
    mem_q.delete();
    ifc.imem_rsp_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    chk_eq("t6_req_rel", {31'd0, ifc.imem_req_valid}, 32'd1);
    tick();
    tick();
    chk_eq("t6_refetch", pcplus8_d, 32'h0000_0008);
    chk_eq("t6_instr0", instr_d, word_at(32'h0000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
